// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan controller.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Clocks per line.
   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   // Lines per frame.
   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pixel_t;

   // hs/vs are "in sync pulse" flags; polarity is applied only at the pins.
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } scan_state_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that holds timing flags while the framebuffer
// read is in flight, so syncs reach the pins alongside their pixel data.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic  i_clk,
   input  logic  i_clr,
   input  sync_t i_d,
   output sync_t o_q
);

   sync_t r_stage [DEPTH];

   // Advance one stage per clock; clear flushes every stage to blank/inactive.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= SYNC_IDLE;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA display engine: raster counters, framebuffer read requests, and
// pin-level sync/colour re-aligned to the framebuffer read latency.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | counters parked at 0, no requests, syncs inactive, RGB black
//   ST_RUN  | raster scanning; leaves only at the last clock of a frame
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   RD_LAT   = 2,
   parameter int   ADDR_W   = 19
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [ADDR_W-1:0] fb_base_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [11:0]       rd_data_i,
   output logic              vga_hs_o,
   output logic              vga_vs_o,
   output logic [3:0]        vga_r_o,
   output logic [3:0]        vga_g_o,
   output logic [3:0]        vga_b_o,
   output logic              frame_start_o,
   output logic              vblank_o
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [HW-1:0]     H_ONE    = HW'(1);
   localparam logic [VW-1:0]     V_ONE    = VW'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic [HW-1:0]     r_h_cnt;
   logic [HW-1:0]     w_h_nxt;
   logic [VW-1:0]     r_v_cnt;
   logic [VW-1:0]     w_v_nxt;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] w_base_nxt;

   logic              w_running;
   logic              w_h_last;
   logic              w_v_last;
   logic              w_origin;

   logic              r_active;
   logic              r_hs_t;
   logic              r_vs_t;
   logic              r_vblank;
   logic              r_frame_start;
   logic [ADDR_W-1:0] r_addr;

   sync_t             w_sync_t;
   sync_t             w_sync_d;
   pixel_t            w_pix;

   logic              r_hs;
   logic              r_vs;
   logic [3:0]        r_r;
   logic [3:0]        r_g;
   logic [3:0]        r_b;

   assign w_running = (r_state == ST_RUN);
   assign w_h_last  = (r_h_cnt == H_LAST);
   assign w_v_last  = (r_v_cnt == V_LAST);
   assign w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);

   // State, raster counters and latched base address.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_base  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
         r_base  <= w_base_nxt;
      end
   end

   // Next state and counter update; the base only moves at a frame boundary
   // so a mid-frame base write cannot tear the picture.
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h_cnt;
      w_v_nxt     = r_v_cnt;
      w_base_nxt  = r_base;
      case (r_state)
         ST_IDLE: begin
            w_h_nxt = '0;
            w_v_nxt = '0;
            if (enable_i) begin
               w_state_nxt = ST_RUN;
               w_base_nxt  = fb_base_i;
            end
         end
         ST_RUN: begin
            if (w_h_last) begin
               w_h_nxt = '0;
               if (w_v_last) begin
                  w_v_nxt = '0;
                  if (enable_i) w_base_nxt  = fb_base_i;
                  else          w_state_nxt = ST_IDLE;
               end else begin
                  w_v_nxt = r_v_cnt + V_ONE;
               end
            end else begin
               w_h_nxt = r_h_cnt + H_ONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Timing-domain flags and the read address, one clock behind the counters.
   // The address reloads at the frame origin and otherwise steps once after
   // each issued request, so it parks on the next pixel through blanking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_active      <= 1'b0;
         r_hs_t        <= 1'b0;
         r_vs_t        <= 1'b0;
         r_vblank      <= 1'b0;
         r_frame_start <= 1'b0;
         r_addr        <= '0;
      end else begin
         r_active      <= w_running && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
         r_hs_t        <= w_running && (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
         r_vs_t        <= w_running && (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
         r_vblank      <= w_running && (r_v_cnt >= V_ACT);
         r_frame_start <= w_running && w_origin;
         if (w_running && w_origin) r_addr <= r_base;
         else if (r_active)         r_addr <= r_addr + ADDR_ONE;
      end
   end

   assign w_sync_t = '{active: r_active, hs: r_hs_t, vs: r_vs_t};

   vga_delay_line #(
      .DEPTH (RD_LAT)
   ) u_delay (
      .i_clk (clk_i),
      .i_clr (rst_i),
      .i_d   (w_sync_t),
      .o_q   (w_sync_d)
   );

   assign w_pix = pixel_t'(rd_data_i);

   // Pin register: delayed syncs and returned colour captured on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
         r_r  <= '0;
         r_g  <= '0;
         r_b  <= '0;
      end else begin
         r_hs <= w_sync_d.hs ? HS_POL : ~HS_POL;
         r_vs <= w_sync_d.vs ? VS_POL : ~VS_POL;
         if (w_sync_d.active) begin
            r_r <= w_pix.r;
            r_g <= w_pix.g;
            r_b <= w_pix.b;
         end else begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
         end
      end
   end

   assign rd_en_o       = r_active;
   assign rd_addr_o     = r_addr;
   assign frame_start_o = r_frame_start;
   assign vblank_o      = r_vblank;
   assign vga_hs_o      = r_hs;
   assign vga_vs_o      = r_vs;
   assign vga_r_o       = r_r;
   assign vga_g_o       = r_g;
   assign vga_b_o       = r_b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunk 16x6 raster (25 clocks x 10 lines,
// 250 clocks per frame) so whole frames fit in a short run.
// Cycle t = 0 is the cycle rd_en_o is high for pixel (0,0) of frame 1.
module tb_vga_scan_ctrl;

   localparam int ADDR_W = 19;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              enable_i;
   logic [ADDR_W-1:0] fb_base_i;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [11:0]       rd_data_i = 12'hFFF;
   logic              vga_hs_o;
   logic              vga_vs_o;
   logic [3:0]        vga_r_o;
   logic [3:0]        vga_g_o;
   logic [3:0]        vga_b_o;
   logic              frame_start_o;
   logic              vblank_o;

   int n_tests = 0;
   int n_fail  = 0;

   vga_scan_ctrl #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
      .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL (1'b0), .VS_POL (1'b0), .RD_LAT (2), .ADDR_W (ADDR_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (enable_i),
      .fb_base_i     (fb_base_i),
      .rd_en_o       (rd_en_o),
      .rd_addr_o     (rd_addr_o),
      .rd_data_i     (rd_data_i),
      .vga_hs_o      (vga_hs_o),
      .vga_vs_o      (vga_vs_o),
      .vga_r_o       (vga_r_o),
      .vga_g_o       (vga_g_o),
      .vga_b_o       (vga_b_o),
      .frame_start_o (frame_start_o),
      .vblank_o      (vblank_o)
   );

   always #5 clk_i = ~clk_i;

   // RAM contents: one marked word at 0x1005, otherwise address-derived.
   function automatic logic [11:0] ram_word(input logic [ADDR_W-1:0] a);
      if (a == 19'h01005) return 12'hABC;
      return a[11:0] + {a[15:12], 8'h23};
   endfunction

   // Two-clock-latency RAM; returns 0xFFF for cycles without a request.
   logic [11:0] p0 = 12'hFFF, p1 = 12'hFFF, p2 = 12'hFFF;
   always @(negedge clk_i) begin
      p2 = p1;
      p1 = p0;
      p0 = rd_en_o ? ram_word(rd_addr_o) : 12'hFFF;
      rd_data_i = p2;
   end

   typedef struct {
      int                t;
      logic              rd_en;
      logic [ADDR_W-1:0] addr;
      logic              fs;
      logic              vb;
      logic              hs;
      logic              vs;
      logic [11:0]       rgb;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int t, input logic rd_en, input logic [ADDR_W-1:0] addr,
                               input logic fs, input logic vb, input logic hs, input logic vs,
                               input logic [11:0] rgb);
      vec_t v;
      v.t = t; v.rd_en = rd_en; v.addr = addr; v.fs = fs; v.vb = vb;
      v.hs = hs; v.vs = vs; v.rgb = rgb;
      vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
      end
   endtask

   task automatic chk_vec(input vec_t v);
      chk("rd_en",       v.t, rd_en_o,                       v.rd_en);
      chk("rd_addr",     v.t, rd_addr_o,                     v.addr);
      chk("frame_start", v.t, frame_start_o,                 v.fs);
      chk("vblank",      v.t, vblank_o,                      v.vb);
      chk("hs",          v.t, vga_hs_o,                      v.hs);
      chk("vs",          v.t, vga_vs_o,                      v.vs);
      chk("rgb",         v.t, {vga_r_o, vga_g_o, vga_b_o},   v.rgb);
   endtask

   task automatic chk_reset(input string tag, input int t);
      chk({tag, "_rd_en"}, t, rd_en_o,                     0);
      chk({tag, "_addr"},  t, rd_addr_o,                   0);
      chk({tag, "_fs"},    t, frame_start_o,               0);
      chk({tag, "_vb"},    t, vblank_o,                    0);
      chk({tag, "_hs"},    t, vga_hs_o,                    1);
      chk({tag, "_vs"},    t, vga_vs_o,                    1);
      chk({tag, "_rgb"},   t, {vga_r_o, vga_g_o, vga_b_o}, 0);
   endtask

   initial begin
      int vi;
      int fs_cnt;
      int rd_cnt;

      //   t    rd_en  addr       fs  vb  hs  vs  rgb      (pins show pixel t-3)
      add(  0, 1'b1, 19'h01000, 1, 0, 1, 1, 12'h000);
      add(  1, 1'b1, 19'h01001, 0, 0, 1, 1, 12'h000);
      add(  3, 1'b1, 19'h01003, 0, 0, 1, 1, 12'h123);
      add(  7, 1'b1, 19'h01007, 0, 0, 1, 1, 12'h127);
      add(  8, 1'b1, 19'h01008, 0, 0, 1, 1, 12'hABC);
      add(  9, 1'b1, 19'h01009, 0, 0, 1, 1, 12'h129);
      add( 15, 1'b1, 19'h0100F, 0, 0, 1, 1, 12'h12F);
      add( 16, 1'b0, 19'h01010, 0, 0, 1, 1, 12'h130);
      add( 19, 1'b0, 19'h01010, 0, 0, 1, 1, 12'h000);
      add( 21, 1'b0, 19'h01010, 0, 0, 0, 1, 12'h000);
      add( 24, 1'b0, 19'h01010, 0, 0, 0, 1, 12'h000);
      add( 25, 1'b1, 19'h01010, 0, 0, 1, 1, 12'h000);
      add( 28, 1'b1, 19'h01013, 0, 0, 1, 1, 12'h133);
      add(125, 1'b1, 19'h01050, 0, 0, 1, 1, 12'h000);
      add(150, 1'b0, 19'h01060, 0, 1, 1, 1, 12'h000);
      add(178, 1'b0, 19'h01060, 0, 1, 1, 0, 12'h000);
      add(199, 1'b0, 19'h01060, 0, 1, 0, 0, 12'h000);
      add(227, 1'b0, 19'h01060, 0, 1, 1, 0, 12'h000);
      add(228, 1'b0, 19'h01060, 0, 1, 1, 1, 12'h000);
      add(249, 1'b0, 19'h01060, 0, 1, 0, 1, 12'h000);
      add(250, 1'b1, 19'h02000, 1, 0, 1, 1, 12'h000);
      add(253, 1'b1, 19'h02003, 0, 0, 1, 1, 12'h223);
      add(255, 1'b1, 19'h02005, 0, 0, 1, 1, 12'h225);
      add(375, 1'b1, 19'h02050, 0, 0, 1, 1, 12'h000);
      add(378, 1'b1, 19'h02053, 0, 0, 1, 1, 12'h273);
      add(499, 1'b0, 19'h02060, 0, 1, 0, 1, 12'h000);
      add(500, 1'b0, 19'h02060, 0, 0, 1, 1, 12'h000);
      add(502, 1'b0, 19'h02060, 0, 0, 1, 1, 12'h000);
      add(520, 1'b0, 19'h02060, 0, 0, 1, 1, 12'h000);

      // Reset held with enable high: reset must win.
      rst_i     = 1'b1;
      enable_i  = 1'b1;
      fb_base_i = 19'h01000;
      repeat (3) step();
      chk_reset("reset", -1);

      rst_i = 1'b0;
      step();

      // Two frames: base moves to 0x2000 during line 4 of frame 1, enable
      // drops during line 4 of frame 2.
      vi     = 0;
      fs_cnt = 0;
      rd_cnt = 0;
      for (int t = 0; t <= 520; t++) begin
         step();
         fs_cnt += int'(frame_start_o);
         rd_cnt += int'(rd_en_o);
         if (vi < vecs.size() && vecs[vi].t == t) begin
            chk_vec(vecs[vi]);
            vi++;
         end
         fb_base_i = (t >= 100) ? 19'h02000 : 19'h01000;
         enable_i  = (t < 350);
      end
      chk("frame_start_count", 520, fs_cnt, 2);
      chk("rd_en_count",       520, rd_cnt, 192);

      // Address wrap across 2^19, then a reset in the middle of the line.
      fb_base_i = 19'h7FFF6;
      enable_i  = 1'b1;
      step();
      for (int s = 0; s < 14; s++) begin
         step();
         chk("wrap_rd_en", s, rd_en_o, 1);
         chk("wrap_addr",  s, rd_addr_o, 19'(19'h7FFF6 + s));
         if (s == 0) chk("wrap_fs", s, frame_start_o, 1);
      end
      rst_i = 1'b1;
      step();
      chk_reset("midline_reset", 14);
      rst_i    = 1'b0;
      enable_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("flush_rgb",   15 + k, {vga_r_o, vga_g_o, vga_b_o}, 0);
         chk("flush_rd_en", 15 + k, rd_en_o, 0);
         chk("flush_hs",    15 + k, vga_hs_o, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Display engine of the APB VGA peripheral. Generates raster timing, issues framebuffer read requests, and drives the pin-level outputs vga_hs_o/vga_vs_o/vga_r_o/vga_g_o/vga_b_o.
- The framebuffer RAM sits upstream and answers each read with a fixed latency.
- Sync and colour are re-aligned inside this block so that the board sees coherent pixels.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- RD_LAT, 2, framebuffer read latency in clocks (1..4)
- ADDR_W, 19, framebuffer word address width

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset; synchronous, active-high
- enable_i  in  1  scan enable from APB control register
- fb_base_i  in  ADDR_W  framebuffer base word address
- rd_en_o  out  1  read strobe, one per active pixel
- rd_addr_o  out  ADDR_W  read address
- rd_data_i  in  12  {R[11:8],G[7:4],B[3:0]}, valid RD_LAT clocks after rd_en_o
- vga_hs_o  out  1  horizontal sync
- vga_vs_o  out  1  vertical sync
- vga_r_o  out  4  red
- vga_g_o  out  4  green
- vga_b_o  out  4  blue
- frame_start_o  out  1  one-clock pulse at pixel (0,0) request
- vblank_o  out  1  high while v_cnt >= V_ACTIVE (timing domain, undelayed)

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset values: all outputs 0 except vga_hs_o = !HS_POL and vga_vs_o = !VS_POL. Counters = 0, running = 0, delay line cleared to the inactive/blank state.
- Reset asserted mid-frame returns everything to the reset values on the next edge, including in-flight delay-line contents.
- State: IDLE / RUN, held in a running flag.
- IDLE -> RUN: on the edge where enable_i = 1. At that edge h_cnt = v_cnt = 0 and fb_base_i is latched into base_q.
- RUN -> IDLE: only at the frame end (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1 with enable_i = 0). A mid-frame deassert completes the current frame.
- In IDLE: counters held at 0, rd_en_o = 0, syncs inactive, RGB = 0.
- Counters (RUN): h_cnt increments each clock and wraps at H_TOTAL-1 -> 0. v_cnt increments on the h wrap and wraps at V_TOTAL-1 -> 0.
- At the frame wrap with enable_i = 1, fb_base_i is re-latched. A base change mid-frame is therefore invisible until the next frame.
- Timing-domain signals, all registered:
  - active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE
  - hs_t = (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
  - vs_t = (V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC)
- Requests:
  - rd_en_o = active & running.
  - rd_addr_o is an incremental counter: base_q at pixel (0,0), +1 per active pixel, no multiplier.
  - Wraps modulo 2^ADDR_W.
  - Holds its value during blanking.
- Alignment:
  - {active, hs_t, vs_t} pass through a delay of RD_LAT stages. The output register then captures delayed syncs together with rd_data_i.
  - Total request-to-pin latency = RD_LAT+1 clocks for sync and colour alike.
  - When delayed active = 0, RGB = 0 regardless of rd_data_i.
  - vga_hs_o = hs_d ? HS_POL : !HS_POL; vga_vs_o likewise with VS_POL.
- frame_start_o: high exactly in the cycle rd_en_o is issued for pixel (0,0).
- Simultaneous rst_i and enable_i: reset wins.

Decomposition:
- Package vga_pkg: default timing constants (H_*/V_* for 640x480@60), derived H_TOTAL/V_TOTAL functions, packed struct pixel_t {r,g,b}, and struct sync_t {active,hs,vs}.
- One sub-module, vga_delay_line: parameterised-depth shift register of sync_t with synchronous clear. It is instantiated once for the RD_LAT alignment.

Test Plan:
- Reset: hold rst_i 3 clocks with enable_i = 1 -> vga_hs_o = 1, vga_vs_o = 1, RGB = 0, rd_en_o = 0, frame_start_o = 0; reassert mid-line at h_cnt = 300 -> same values next edge.
- Line timing: enable with fb_base_i = 0x1000 -> rd_en_o high for 640 clocks with rd_addr_o 0x1000..0x127F, then low for 160. vga_hs_o is low for clocks 656..751 of each line, offset by +3 (RD_LAT = 2).
- Frame timing: frame_start_o pulses every 420000 clocks. vga_vs_o is low for lines 490–491 (1600 clocks). The address for line 1 pixel 0 is 0x1000+640. vblank_o is high for lines 480..524.
- Data alignment: model RAM with 2-clock latency returning 12'hABC at pixel 5 of line 0 -> R = 0xA, G = 0xB, B = 0xC exactly 3 clocks after that request, neighbouring pixels unaffected. Drive rd_data_i = 12'hFFF during blanking -> RGB stays 0.
- Enable and base changes: deassert enable_i at line 100 -> scanning continues to the frame end, then idle (syncs inactive). Change fb_base_i to 0x2000 at line 200 -> addresses unchanged this frame, next frame starts at 0x2000.
- Address wrap: fb_base_i = 2^19 − 10 -> rd_addr_o wraps to 0 after 10 pixels; no glitch on rd_en_o.
